cordic_seq_ctrl: RTL and testbench

CORDIC_SEQ_CTRL -- requirements
Module: cordic_seq_ctrl

---
 rtl/cordic_pkg.sv | 18 +
 rtl/cordic_seq_ctrl.sv | 101 ++++++++++
 tb/tb_cordic_seq_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC sequencing controller: FSM states,
// operation mode encoding and default iteration geometry.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic ROTATION  = 1'b0;
  localparam logic VECTORING = 1'b1;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int NO_MUX_DEF     = 4;
  localparam int NUM_GROUPS_DEF = 3;

endpackage

// File: rtl/cordic_seq_ctrl.sv
// Sequencer for an iterative CORDIC datapath: accepts one operand set, steps
// the arctan LUT group select through NUM_GROUPS cycles, then holds the result.
module cordic_seq_ctrl
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NO_MUX     = NO_MUX_DEF,
  parameter int NUM_GROUPS = NUM_GROUPS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      mode_in,
  output logic                      mode,
  output logic                      load_en,
  output logic                      stage_en,
  output logic [$clog2(NO_MUX)-1:0] itter_select,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic [15:0]               op_count
);

  localparam int SEL_W = $clog2(NO_MUX);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_GROUPS - 1);

  // The select must be able to encode every group index.
  if (DATA_WIDTH < 1 || NUM_GROUPS < 1 || NUM_GROUPS > (2 ** SEL_W)) begin : g_param_chk
    $error("cordic_seq_ctrl: illegal parameter combination");
  end

  state_t            state_reg, state_next;
  logic [SEL_W-1:0]  sel_reg, sel_next;
  logic              mode_reg, mode_next;
  logic [15:0]       count_reg, count_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      mode_reg  <= ROTATION;
      count_reg <= 16'd0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      mode_reg  <= mode_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    mode_next  = mode_reg;
    count_next = count_reg;
    in_ready   = 1'b0;
    load_en    = 1'b0;
    stage_en   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        load_en  = in_valid;
        if (in_valid) begin
          state_next = ITER;
          sel_next   = '0;
          mode_next  = mode_in;
        end
      end
      ITER: begin
        stage_en = 1'b1;
        // Return the select to 0 on the last group so DONE presents 0.
        if (sel_reg == LAST_SEL) begin
          state_next = DONE;
          sel_next   = '0;
        end else begin
          sel_next = sel_reg + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
          count_next = count_reg + 16'd1;
        end
      end
      default: begin
        state_next = IDLE;
        sel_next   = '0;
      end
    endcase
  end

  assign itter_select = sel_reg;
  assign mode         = mode_reg;
  assign op_count     = count_reg;

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Self-checking bench for cordic_seq_ctrl: directed scenarios then random
// traffic, each cycle compared against a cycle-offset timing model.
module tb_cordic_seq_ctrl;

  localparam int NG = 3;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        mode_in;
  logic        mode;
  logic        load_en;
  logic        stage_en;
  logic [1:0]  itter_select;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [15:0] op_count;

  cordic_seq_ctrl #(.DATA_WIDTH(16), .NO_MUX(4), .NUM_GROUPS(NG)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mode_in      (mode_in),
    .mode         (mode),
    .load_en      (load_en),
    .stage_en     (stage_en),
    .itter_select (itter_select),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .op_count     (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int cyc_n      = 0;

  // Model: phase = cycles elapsed since acceptance (-1 when idle).
  // 1..NG are the iteration cycles, NG+1 is the result-holding phase.
  int          phase;
  logic        m_mode;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc_n, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic m, input logic r, input logic o);
    logic idle, iter, done;
    rst       = r;
    in_valid  = v;
    mode_in   = m;
    out_ready = o;
    #1;
    idle = (phase < 0);
    iter = (phase >= 1) && (phase <= NG);
    done = (phase == NG + 1);
    chk("in_ready", {15'd0, in_ready}, {15'd0, idle});
    chk("load_en", {15'd0, load_en}, {15'd0, idle & v});
    chk("stage_en", {15'd0, stage_en}, {15'd0, iter});
    chk("itter_select", {14'd0, itter_select}, iter ? 16'(phase - 1) : 16'd0);
    chk("out_valid", {15'd0, out_valid}, {15'd0, done});
    chk("busy", {15'd0, busy}, {15'd0, ~idle});
    chk("mode", {15'd0, mode}, {15'd0, m_mode});
    chk("op_count", op_count, m_cnt);
    @(posedge clk);
    if (r) begin
      phase  = -1;
      m_mode = 1'b0;
      m_cnt  = 16'd0;
    end else if (idle) begin
      if (v) begin
        phase  = 1;
        m_mode = m;
      end
    end else if (iter) begin
      phase = phase + 1;
    end else if (o) begin
      phase = -1;
      m_cnt = m_cnt + 16'd1;
    end
    cyc_n++;
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    mode_in   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    phase  = -1;
    m_mode = 1'b0;
    m_cnt  = 16'd0;

    // Reset state, including an input request while reset is held.
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Single vectoring operation with an immediately ready consumer.
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (6) cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure: result held for several cycles before being taken.
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (NG + 6) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Requests and mode toggling during ITER and DONE are ignored.
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < NG + 3; i++) cyc(1'b1, i[0], 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset two cycles after acceptance aborts the operation.
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (NG + 2) cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Counter wrap: preload all-ones, then complete one operation.
    force dut.count_reg = 16'hFFFF;
    #1;
    release dut.count_reg;
    m_cnt = 16'hFFFF;
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (NG + 2) cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back operations with both handshakes always asserted.
    repeat (4 * (NG + 2)) cyc(1'b1, 1'($urandom), 1'b0, 1'b1);

    // Random traffic with occasional resets.
    repeat (400) cyc(1'($urandom), 1'($urandom), ($urandom_range(0, 39) == 0),
                     ($urandom_range(0, 2) != 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
